// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants, the mic-clock edge type and the saturation helper
// used by the PDM audio front end.
package pdm_pkg;

  // Mic clock: default clk_in cycles per mic clock period and its level in reset.
  localparam int unsigned MIC_CLK_DIV_DEFAULT = 32;
  localparam logic        MIC_CLK_RESET_LEVEL = 1'b0;

  // Running-mean time constant of the optional DC blocker (m += (x-m) >>> DC_SHIFT).
  localparam int unsigned DC_SHIFT = 8;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } mic_edge_e;

  // Clamp a signed value into the signed range of a w-bit word (w <= 31).
  function automatic logic signed [31:0] sat(input logic signed [31:0] x,
                                             input int unsigned        w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pdm_tally_channel.sv
// pdm_tally_channel: counts PDM ones on its strobe over one decimation window
// and converts the count into a signed, saturated sample.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : holds the tally at zero (capture disabled)
//   strobe      : sampling strobe for this channel (rise or fall of mic clock)
//   pdm_bit     : PDM data bit
//   boundary    : end of the decimation window; tally restarts at zero
//   sample      : conversion of the tally including the bit of this cycle
module pdm_tally_channel
  import pdm_pkg::*;
#(
  parameter int unsigned DECIM = 256,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             strobe,
  input  logic             pdm_bit,
  input  logic             boundary,
  output logic [OUT_W-1:0] sample
);

  localparam int unsigned LOG2  = $clog2(DECIM);
  localparam int unsigned TW    = LOG2 + 1;
  localparam int unsigned SHIFT = OUT_W - LOG2;
  localparam logic signed [31:0] MID = 32'(DECIM / 2);

  logic [TW-1:0]      tally;
  logic [TW-1:0]      tally_sum;
  logic signed [31:0] centered;
  logic signed [31:0] scaled;
  logic signed [31:0] clipped;

  // The sample is taken from tally_sum so the bit landing on the boundary
  // strobe itself is part of the window it completes.
  always_comb begin
    tally_sum = tally + {{(TW-1){1'b0}}, strobe & pdm_bit};
    centered  = $signed({{(32-TW){1'b0}}, tally_sum}) - MID;
    scaled    = centered <<< SHIFT;
    clipped   = sat(scaled, OUT_W);
    sample    = clipped[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear || boundary) begin
      tally <= '0;
    end else begin
      tally <= tally_sum;
    end
  end

endmodule

// File: rtl/pdm_audio_frontend.sv
// pdm_audio_frontend: PDM microphone front end. Generates the mic clock,
// tallies PDM bits per channel (channel 0 on mic clock rise, channel 1 on
// fall), decimates by DECIM and streams samples out over AXI-stream with a
// frame marker every FRAME_LEN beats.
//   clk_in, rst_in  : clock, synchronous active-high reset
//   enable_in       : capture enable (mic clock keeps running when low)
//   mic_clk_out     : microphone clock
//   mic_data_in     : PDM data
//   m_tdata         : NUM_CH samples of OUT_W bits, channel 0 in the LSBs
//   m_tvalid/m_tready/m_tlast : AXI-stream handshake
//   overflow_out    : sticky flag, a sample was dropped while a beat was pending
// Build option: define PDM_DC_BLOCK_EN to subtract a per-channel running mean
// (adds one cycle of latency).
module pdm_audio_frontend
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV   = MIC_CLK_DIV_DEFAULT,
  parameter int unsigned DECIM     = 256,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned NUM_CH    = 1,
  parameter int unsigned FRAME_LEN = 1024
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  output logic                    mic_clk_out,
  input  logic                    mic_data_in,
  output logic [NUM_CH*OUT_W-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    overflow_out
);

  localparam int unsigned CW   = $clog2(CLK_DIV);
  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned PW   = $clog2(DECIM);
  localparam int unsigned FW   = $clog2(FRAME_LEN);

  // Mic clock divider and edge strobes
  logic [CW-1:0] div_cnt;
  logic          mic_clk;
  logic          mic_clk_d;
  mic_edge_e     mic_edge;
  logic          rise;
  logic          fall;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt   <= '0;
      mic_clk   <= MIC_CLK_RESET_LEVEL;
      mic_clk_d <= MIC_CLK_RESET_LEVEL;
    end else begin
      div_cnt   <= (div_cnt == CW'(CLK_DIV - 1)) ? '0 : div_cnt + CW'(1);
      mic_clk   <= (div_cnt < CW'(HALF));
      mic_clk_d <= mic_clk;
    end
  end

  always_comb begin
    mic_edge = EDGE_NONE;
    if (mic_clk && !mic_clk_d) begin
      mic_edge = EDGE_RISE;
    end else if (!mic_clk && mic_clk_d) begin
      mic_edge = EDGE_FALL;
    end
  end

  assign rise        = (mic_edge == EDGE_RISE);
  assign fall        = (mic_edge == EDGE_FALL);
  assign mic_clk_out = mic_clk;

  // Decimation window: a period ends on the fall strobe
  logic [PW-1:0] period_cnt;
  logic          boundary;

  assign boundary = enable_in && fall && (period_cnt == PW'(DECIM - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in || !enable_in) begin
      period_cnt <= '0;
    end else if (fall) begin
      period_cnt <= boundary ? '0 : period_cnt + PW'(1);
    end
  end

  // Per-channel tally and conversion
  logic [NUM_CH*OUT_W-1:0] sample_bus;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pdm_tally_channel #(
      .DECIM (DECIM),
      .OUT_W (OUT_W)
    ) u_tally (
      .clk      (clk_in),
      .rst      (rst_in),
      .clear    (!enable_in),
      .strobe   ((c == 0) ? rise : fall),
      .pdm_bit  (mic_data_in),
      .boundary (boundary),
      .sample   (sample_bus[c*OUT_W +: OUT_W])
    );
  end

  logic                    new_sample;
  logic [NUM_CH*OUT_W-1:0] new_data;

`ifdef PDM_DC_BLOCK_EN
  logic                    dc_pending;
  logic [NUM_CH*OUT_W-1:0] dc_x;
  logic [NUM_CH*OUT_W-1:0] dc_y;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dc_pending <= 1'b0;
      dc_x       <= '0;
    end else begin
      dc_pending <= boundary;
      if (boundary) begin
        dc_x <= sample_bus;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_dc
    logic signed [OUT_W-1:0] x_c;
    logic signed [OUT_W-1:0] mean;
    logic signed [31:0]      diff;
    logic signed [31:0]      step;
    logic signed [31:0]      y_w;

    always_comb begin
      x_c  = dc_x[c*OUT_W +: OUT_W];
      diff = {{(32-OUT_W){x_c[OUT_W-1]}}, x_c} - {{(32-OUT_W){mean[OUT_W-1]}}, mean};
      step = diff >>> DC_SHIFT;
      y_w  = sat(diff, OUT_W);
    end

    assign dc_y[c*OUT_W +: OUT_W] = y_w[OUT_W-1:0];

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        mean <= '0;
      end else if (dc_pending) begin
        mean <= mean + step[OUT_W-1:0];
      end
    end
  end

  assign new_sample = dc_pending;
  assign new_data   = dc_y;
`else
  assign new_sample = boundary;
  assign new_data   = sample_bus;
`endif

  // Output beat register and frame index
  logic [FW-1:0] frame_idx;
  logic [FW-1:0] frame_next;
  logic          beat_done;

  // frame_next already reflects a beat retiring this cycle, so a sample loaded
  // in the same cycle gets the index of the following beat.
  always_comb begin
    beat_done  = m_tvalid && m_tready;
    frame_next = frame_idx;
    if (beat_done) begin
      frame_next = (frame_idx == FW'(FRAME_LEN - 1)) ? '0 : frame_idx + FW'(1);
    end
    if (!enable_in) begin
      frame_next = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_idx    <= '0;
      m_tvalid     <= 1'b0;
      m_tlast      <= 1'b0;
      m_tdata      <= '0;
      overflow_out <= 1'b0;
    end else begin
      frame_idx <= frame_next;
      if (beat_done) begin
        m_tvalid <= 1'b0;
      end
      if (new_sample) begin
        if (m_tvalid && !m_tready) begin
          overflow_out <= 1'b1;
        end else begin
          m_tvalid <= 1'b1;
          m_tdata  <= new_data;
          m_tlast  <= (frame_next == FW'(FRAME_LEN - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_audio_frontend.sv
// tb_pdm_audio_frontend: scoreboard bench for pdm_audio_frontend.
// Instance a: default parameters (single channel, 8192 cycles per sample).
// Instance b: CLK_DIV=4, DECIM=16, NUM_CH=2, FRAME_LEN=4 (64 cycles per sample).
`timescale 1ns/1ps
module tb_pdm_audio_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- instance a (defaults) ----------------
  logic        a_rst = 1'b1;
  logic        a_en = 1'b1;
  logic        a_data = 1'b0;
  logic        a_mclk;
  logic [15:0] a_tdata;
  logic        a_valid;
  logic        a_ready = 1'b1;
  logic        a_last;
  logic        a_ovf;
  int          a_mode = 0;   // 0: constant 0, 1: constant 1, 2: alternate per period
  int          a_pops = 0;
  logic [16:0] a_exp[$];     // {tlast, tdata}

  pdm_audio_frontend #(
    .CLK_DIV   (32),
    .DECIM     (256),
    .OUT_W     (16),
    .NUM_CH    (1),
    .FRAME_LEN (1024)
  ) dut_a (
    .clk_in       (clk),
    .rst_in       (a_rst),
    .enable_in    (a_en),
    .mic_clk_out  (a_mclk),
    .mic_data_in  (a_data),
    .m_tdata      (a_tdata),
    .m_tvalid     (a_valid),
    .m_tready     (a_ready),
    .m_tlast      (a_last),
    .overflow_out (a_ovf)
  );

  // ---------------- instance b (2 channels, short frames) ----------------
  logic        b_rst = 1'b1;
  logic        b_en = 1'b1;
  logic        b_data = 1'b0;
  logic        b_mclk;
  logic [31:0] b_tdata;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic        b_last;
  logic        b_ovf;
  int          b_pops = 0;
  logic [32:0] b_exp[$];     // {tlast, tdata}

  pdm_audio_frontend #(
    .CLK_DIV   (4),
    .DECIM     (16),
    .OUT_W     (16),
    .NUM_CH    (2),
    .FRAME_LEN (4)
  ) dut_b (
    .clk_in       (clk),
    .rst_in       (b_rst),
    .enable_in    (b_en),
    .mic_clk_out  (b_mclk),
    .mic_data_in  (b_data),
    .m_tdata      (b_tdata),
    .m_tvalid     (b_valid),
    .m_tready     (b_ready),
    .m_tlast      (b_last),
    .overflow_out (b_ovf)
  );

  // PDM data for a: alternating mode flips the bit once per mic clock period.
  task automatic set_a_mode(input int m);
    a_mode = m;
    if (m != 2) a_data = (m == 1);
  endtask

  initial begin
    forever begin
      @(posedge a_mclk);
      if (a_mode == 2) a_data = ~a_data;
    end
  end

  // PDM data for b follows the mic clock: 1 on rise strobes, 0 on fall strobes.
  initial begin
    forever begin
      @(b_mclk);
      b_data = b_mclk;
    end
  end

  // ---------------- monitors ----------------
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (a_valid && a_ready) begin
        if (a_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_beat: got 0x%0h, expected no beat", {a_last, a_tdata});
        end else begin
          e = a_exp.pop_front();
          check($sformatf("a_beat%0d", a_pops), {47'd0, a_last, a_tdata}, {47'd0, e});
        end
        a_pops++;
      end
    end
  end

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (b_valid && b_ready) begin
        if (b_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_beat: got 0x%0h, expected no beat", {b_last, b_tdata});
        end else begin
          e = b_exp.pop_front();
          check($sformatf("b_beat%0d", b_pops), {31'd0, b_last, b_tdata}, {31'd0, e});
        end
        b_pops++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_a_pops(input int target, input int budget, input string name);
    int n = 0;
    while (a_pops < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 64'(a_pops >= target), 64'd1);
  endtask

  task automatic wait_b_pops(input int target, input int budget, input string name);
    int n = 0;
    while (b_pops < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 64'(b_pops >= target), 64'd1);
  endtask

  task automatic pulse_a_reset();
    @(posedge clk); #1 a_rst = 1'b1;
    @(posedge clk); #1 a_rst = 1'b0;
  endtask

  // ---------------- sequence for a ----------------
  task automatic run_a();
    int n;
    int unstable;
    int first_at;
    int second_at;

    // Reset state
    set_a_mode(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_reset_outputs", {59'd0, a_mclk, a_valid, a_last, a_ovf, (a_tdata != 16'h0)}, 64'd0);
    @(posedge clk); #1 a_rst = 1'b0;

    // Constant 0 -> most negative code
    a_exp.push_back({1'b0, 16'h8000});
    wait_a_pops(1, 8400, "a_zeros");

    // Alternating periods -> midscale
    set_a_mode(2);
    pulse_a_reset();
    a_exp.push_back({1'b0, 16'h0000});
    wait_a_pops(2, 8400, "a_alt");

    // Back-pressure across two boundaries: second sample dropped
    set_a_mode(1);
    @(posedge clk); #1 a_ready = 1'b0;
    pulse_a_reset();
    n = 0;
    while (!a_valid && n < 8400) begin
      @(negedge clk);
      n++;
    end
    check("a_ovf_first_valid", 64'(a_valid), 64'd1);
    check("a_ovf_first_data", 64'(a_tdata), 64'h7FFF);
    check("a_ovf_clear_before_drop", 64'(a_ovf), 64'd0);
    set_a_mode(0);
    n = 0;
    unstable = 0;
    while (!a_ovf && n < 8400) begin
      @(negedge clk);
      n++;
      if (!a_valid || a_tdata !== 16'h7FFF || a_last !== 1'b0) unstable++;
    end
    check("a_ovf_set", 64'(a_ovf), 64'd1);
    check("a_held_stable_changes", 64'(unstable), 64'd0);
    a_exp.push_back({1'b0, 16'h7FFF});
    a_exp.push_back({1'b0, 16'h8000});
    @(posedge clk); #1 a_ready = 1'b1;
    wait_a_pops(4, 8600, "a_ovf_drain");
    check("a_ovf_sticky", 64'(a_ovf), 64'd1);

    // Reset mid-decimation, then full-length first window
    set_a_mode(1);
    repeat (4000) @(posedge clk);
    #1 a_rst = 1'b1;
    @(posedge clk); #1 a_rst = 1'b0;
    @(negedge clk);
    check("a_midreset_outputs", {59'd0, a_mclk, a_valid, a_last, a_ovf, (a_tdata != 16'h0)}, 64'd0);
    a_exp.push_back({1'b0, 16'h7FFF});
    a_exp.push_back({1'b0, 16'h7FFF});
    n = 0;
    first_at = -1;
    second_at = -1;
    while (second_at < 0 && n < 17000) begin
      @(negedge clk);
      n++;
      if (a_valid) begin
        if (first_at < 0) first_at = n;
        else second_at = n;
      end
    end
    check("a_first_beat_in_window", 64'(first_at >= 8192 - 32 && first_at <= 8192 + 32), 64'd1);
    check("a_beat_interval", 64'(second_at - first_at), 64'd8192);
    wait_a_pops(6, 100, "a_final");
  endtask

  // ---------------- sequence for b ----------------
  task automatic run_b();
    int n;
    logic prev;
    repeat (3) @(posedge clk);
    #1 b_rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      b_exp.push_back({(i == 4 || i == 8), 16'h8000, 16'h7FFF});
    end
    wait_b_pops(10, 900, "b_frames");

    // Enable low after beat 2 of the third frame; index restarts on re-enable
    @(posedge clk); #1 b_en = 1'b0;
    repeat (20) @(posedge clk);
    n = 0;
    prev = 1'b1;
    @(negedge clk);
    while (!(b_mclk && !prev) && n < 20) begin
      prev = b_mclk;
      @(negedge clk);
      n++;
    end
    check("b_reenable_align", 64'(n < 20), 64'd1);
    b_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b_exp.push_back({(i == 4), 16'h8000, 16'h7FFF});
    end
    wait_b_pops(14, 400, "b_reenable");
    @(posedge clk); #1 b_en = 1'b0;
    check("b_no_overflow", 64'(b_ovf), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion, expected completion before 1500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      run_a();
      run_b();
    join
    repeat (100) @(posedge clk);
    check("a_queue_empty", 64'(a_exp.size()), 64'd0);
    check("b_queue_empty", 64'(b_exp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
